// File: rtl/mips_mult_pkg.sv
// Shared definitions for the HI/LO multiply front end: default operand
// width and the sequencing FSM state encoding.
package mips_mult_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_hilo_if.sv
// CPU-side bundle of the HI/LO unit: request, operands, status and the
// architectural HI/LO registers.
//
// Handshake: the CPU raises Start (with Signed/OpA/OpB) for one or more
// cycles; the unit takes the request on the first rising edge where it is
// idle and the multiplier reports Idle. Busy stays high from that edge until
// the unit is ready again; requests seen while Busy is high are dropped, not
// queued. Valid pulses for exactly one cycle, in the cycle after Hi/Lo change.
interface mult_hilo_if import mips_mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Valid;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Signed, OpA, OpB,
        input  Busy, Valid, Hi, Lo
    );

    modport slave (
        input  Start, Signed, OpA, OpB,
        output Busy, Valid, Hi, Lo
    );

endinterface

// File: rtl/mult_sign_fix.sv
// Sign handling around the unsigned shift-add multiplier: operand magnitudes
// on the way in, conditional two's-complement negation on the way out.
// Purely combinational.
module mult_sign_fix import mips_mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               negate,
    input  logic [2*WIDTH-1:0] prod_in,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic [2*WIDTH-1:0] prod_out
);
    localparam int PW = 2 * WIDTH;

    // Magnitudes for MULT; MULTU passes operands through untouched. The
    // most-negative value negates to itself, which is the correct unsigned
    // magnitude, so no special case is needed.
    always_comb begin
        mag_a = op_a;
        mag_b = op_b;
        if (is_signed && op_a[WIDTH-1]) begin
            mag_a = ~op_a + WIDTH'(1);
        end
        if (is_signed && op_b[WIDTH-1]) begin
            mag_b = ~op_b + WIDTH'(1);
        end
    end

    // Restore the product sign; negating zero wraps back to zero.
    always_comb begin
        prod_out = prod_in;
        if (negate) begin
            prod_out = ~prod_in + PW'(1);
        end
    end

endmodule

// File: rtl/mult_hilo.sv
// MULT/MULTU sequencer: captures a CPU request, launches the external
// shift-add multiplier, fixes the product sign and writes HI:LO.
module mult_hilo import mips_mult_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               reset,
    mult_hilo_if.slave         cpu,
    output logic               St,
    output logic [WIDTH-1:0]   Multiplicando,
    output logic [WIDTH-1:0]   Multiplicador,
    input  logic               Idle,
    input  logic               Done,
    input  logic [2*WIDTH-1:0] Produto,
    output state_t             state_dbg,
    output logic               neg_dbg
);
    state_t             state;
    state_t             state_nxt;
    logic               neg_q;
    logic               valid_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic               accept;
    logic               capture;

    // A request is only taken when both this unit and the multiplier are idle.
    assign accept  = (state == S_IDLE) && cpu.Start && Idle;
    // The first Done seen in S_WAIT is the only one that writes HI:LO; any
    // further Done cycles land in S_DRAIN and are ignored.
    assign capture = (state == S_WAIT) && Done;

    mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_signed (cpu.Signed),
        .op_a      (cpu.OpA),
        .op_b      (cpu.OpB),
        .negate    (neg_q),
        .prod_in   (Produto),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .prod_out  (prod_fix)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the launch strobe (decoded from state only, so
    // Done never reaches St combinationally).
    always_comb begin
        state_nxt = state;
        St        = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                St        = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (Done) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Hold here until the multiplier is back to Idle so a
                // lingering Done cannot complete the next operation.
                if (Idle) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes and result sign, frozen at accept so later CPU
    // operand changes have no effect.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= cpu.Signed & (cpu.OpA[WIDTH-1] ^ cpu.OpB[WIDTH-1]);
        end
    end

    // HI:LO write and the one-cycle Valid pulse that follows it.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                {hi_q, lo_q} <= prod_fix;
            end
        end
    end

    assign cpu.Busy      = (state != S_IDLE);
    assign cpu.Valid     = valid_q;
    assign cpu.Hi        = hi_q;
    assign cpu.Lo        = lo_q;
    assign Multiplicando = mcand_q;
    assign Multiplicador = mplier_q;
    assign state_dbg     = state;
    assign neg_dbg       = neg_q;

endmodule

// File: tb/tb_mult_hilo.sv
// Directed bench for mult_hilo with a behavioural stand-in for the
// shift-add multiplier. Inputs change on the falling edge; outputs are
// read on the falling edge or 1 time unit after the rising edge.
module tb_mult_hilo;
    import mips_mult_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic          sgn;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  ma;
        logic [W-1:0]  mb;
        logic          ng;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] hilo;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    mult_hilo_if #(.WIDTH(W)) bus ();

    logic           St;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           Idle    = 1'b1;
    logic           Done    = 1'b0;
    logic [2*W-1:0] Produto = '0;
    state_t         state_dbg;
    logic           neg_dbg;

    mult_hilo #(.WIDTH(W)) dut (
        .Clk           (clk),
        .reset         (reset),
        .cpu           (bus),
        .St            (St),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .Idle          (Idle),
        .Done          (Done),
        .Produto       (Produto),
        .state_dbg     (state_dbg),
        .neg_dbg       (neg_dbg)
    );

    // ---------------- multiplier stand-in ----------------
    int             model_lat  = 2;
    int             model_hold = 1;
    logic [2*W-1:0] model_prod = '0;
    int             m_phase    = 0;
    int             m_cnt      = 0;
    logic           st_n       = 1'b0;
    logic           done_n     = 1'b0;

    always @(negedge clk) begin
        st_n   = St;
        done_n = Done;
    end

    always @(posedge clk) begin
        #2;
        case (m_phase)
            0: if (st_n === 1'b1) begin
                Idle    = 1'b0;
                m_cnt   = model_lat;
                m_phase = 1;
            end
            1: if (m_cnt == 0) begin
                Done    = 1'b1;
                Produto = model_prod;
                m_cnt   = model_hold;
                m_phase = 2;
            end else begin
                m_cnt--;
            end
            2: if (m_cnt <= 1) begin
                Done    = 1'b0;
                Produto = {$urandom, $urandom};
                m_phase = 3;
            end else begin
                m_cnt--;
            end
            default: begin
                Idle    = 1'b1;
                m_phase = 0;
            end
        endcase
    end

    // ---------------- monitor ----------------
    int           st_total      = 0;
    int           valid_total   = 0;
    int           done_total    = 0;
    int           done_at_valid = 0;
    logic [W-1:0] cap_hi        = '0;
    logic [W-1:0] cap_lo        = '0;

    always @(posedge clk) begin
        #1;
        if (done_n === 1'b1) done_total++;
        if (St === 1'b1) st_total++;
        if (bus.Valid === 1'b1) begin
            valid_total++;
            cap_hi        = bus.Hi;
            cap_lo        = bus.Lo;
            done_at_valid = done_total;
        end
    end

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;
    int n_pass  = 0;
    int n_total = 0;

    // per-operation observations filled by do_op
    logic           launch_st, launch_busy, cap_neg, post_done, timed_out;
    logic [W-1:0]   cap_mcand, cap_mplier;
    state_t         post_state;
    logic [2*W-1:0] fin_hilo;
    int             st_d, v_d, lat_d;

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] prod, input int hold);
        int s0, v0, d0, n;
        model_prod = prod;
        model_hold = hold;
        model_lat  = 2;
        timed_out  = 1'b0;
        @(negedge clk);
        s0 = st_total; v0 = valid_total; d0 = done_total;
        bus.Start = 1'b1; bus.Signed = sgn; bus.OpA = a; bus.OpB = b;
        @(negedge clk);
        launch_st   = St;
        launch_busy = bus.Busy;
        cap_mcand   = mcand;
        cap_mplier  = mplier;
        cap_neg     = neg_dbg;
        bus.Start  = 1'b0;
        bus.Signed = ~sgn;
        bus.OpA    = W'($urandom);
        bus.OpB    = W'($urandom);
        n = 0;
        while (valid_total == v0 && n < 40) begin @(negedge clk); n++; end
        if (valid_total == v0) timed_out = 1'b1;
        @(negedge clk);
        post_state = state_dbg;
        post_done  = Done;
        n = 0;
        while (bus.Busy && n < 40) begin @(negedge clk); n++; end
        if (bus.Busy) timed_out = 1'b1;
        @(negedge clk);
        fin_hilo = {bus.Hi, bus.Lo};
        st_d  = st_total - s0;
        v_d   = valid_total - v0;
        lat_d = done_at_valid - d0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus.Start = 1'b1; bus.Signed = 1'b1; bus.OpA = 16'h8000; bus.OpB = 16'h0001;
        @(negedge clk);
        reset = 1'b1;
        bus.Start = 1'b0;
        n_total++; if (state_dbg !== S_IDLE) $display("FAIL rst_state: got %0d expected %0d", state_dbg, S_IDLE); else n_pass++;
        n_total++; if (bus.Busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.Busy); else n_pass++;
        n_total++; if (St !== 1'b0) $display("FAIL rst_st: got %b expected 0", St); else n_pass++;
        n_total++; if (bus.Valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.Valid); else n_pass++;
        n_total++; if ({bus.Hi, bus.Lo} !== 32'h0) $display("FAIL rst_hilo: got %h expected 00000000", {bus.Hi, bus.Lo}); else n_pass++;
        n_total++; if ({mcand, mplier} !== 32'h0) $display("FAIL rst_operands: got %h expected 00000000", {mcand, mplier}); else n_pass++;
        n_total++; if (neg_dbg !== 1'b0) $display("FAIL rst_neg: got %b expected 0", neg_dbg); else n_pass++;
        @(negedge clk);
        n_total++; if ({St, bus.Busy} !== 2'b00) $display("FAIL rst_start_ignored: got St/Busy %b expected 00", {St, bus.Busy}); else n_pass++;
    endtask

    task automatic test_multu_max();
        exp_q.push_back(32'hFFFE_0001);
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1);
        exp_v = exp_q.pop_front();
        n_total++; if (timed_out !== 1'b0) $display("FAIL multu_timeout: got %b expected 0", timed_out); else n_pass++;
        n_total++; if ({launch_st, launch_busy} !== 2'b11) $display("FAIL multu_launch: got St/Busy %b expected 11", {launch_st, launch_busy}); else n_pass++;
        n_total++; if ({cap_mcand, cap_mplier} !== 32'hFFFF_FFFF) $display("FAIL multu_operands: got %h expected ffffffff", {cap_mcand, cap_mplier}); else n_pass++;
        n_total++; if (st_d !== 1) $display("FAIL multu_st_count: got %0d expected 1", st_d); else n_pass++;
        n_total++; if (v_d !== 1) $display("FAIL multu_valid_count: got %0d expected 1", v_d); else n_pass++;
        n_total++; if (lat_d !== 1) $display("FAIL multu_valid_latency: got %0d done edges expected 1", lat_d); else n_pass++;
        n_total++; if ({cap_hi, cap_lo} !== exp_v) $display("FAIL multu_hilo: got %h expected %h", {cap_hi, cap_lo}, exp_v); else n_pass++;
        n_total++; if (fin_hilo !== exp_v) $display("FAIL multu_hilo_hold: got %h expected %h", fin_hilo, exp_v); else n_pass++;
    endtask

    task automatic test_vectors();
        vec_t vecs[6];
        vecs[0] = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0001, 1'b1, 32'h0000_8000, 32'hFFFF_8000};
        vecs[1] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 32'h4000_0000};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 16'hFFFD, 16'h0007, 16'h0003, 16'h0007, 1'b1, 32'h0000_0015, 32'hFFFF_FFEB};
        vecs[4] = '{1'b1, 16'hFFFD, 16'hFFFB, 16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 32'h0000_000F};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].hilo);
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].prod, 1);
            exp_v = exp_q.pop_front();
            n_total++; if ({cap_mcand, cap_mplier} !== {vecs[i].ma, vecs[i].mb}) $display("FAIL vec%0d_operands: got %h expected %h", i, {cap_mcand, cap_mplier}, {vecs[i].ma, vecs[i].mb}); else n_pass++;
            n_total++; if (cap_neg !== vecs[i].ng) $display("FAIL vec%0d_neg: got %b expected %b", i, cap_neg, vecs[i].ng); else n_pass++;
            n_total++; if ({cap_hi, cap_lo} !== exp_v) $display("FAIL vec%0d_hilo: got %h expected %h", i, {cap_hi, cap_lo}, exp_v); else n_pass++;
            n_total++; if (fin_hilo !== exp_v) $display("FAIL vec%0d_hilo_hold: got %h expected %h", i, fin_hilo, exp_v); else n_pass++;
            n_total++; if ({timed_out, v_d} !== {1'b0, 32'sd1}) $display("FAIL vec%0d_valid: got timeout %b count %0d expected 0/1", i, timed_out, v_d); else n_pass++;
        end
    endtask

    task automatic test_hold3();
        exp_q.push_back(32'hFFFF_FFFE);
        do_op(1'b1, 16'h0002, 16'hFFFF, 32'h0000_0002, 3);
        exp_v = exp_q.pop_front();
        n_total++; if (timed_out !== 1'b0) $display("FAIL hold3_timeout: got %b expected 0", timed_out); else n_pass++;
        n_total++; if (v_d !== 1) $display("FAIL hold3_valid_count: got %0d expected 1", v_d); else n_pass++;
        n_total++; if ({post_state, post_done} !== {S_DRAIN, 1'b1}) $display("FAIL hold3_drain: got state %0d done %b expected %0d/1", post_state, post_done, S_DRAIN); else n_pass++;
        n_total++; if ({cap_hi, cap_lo} !== exp_v) $display("FAIL hold3_hilo: got %h expected %h", {cap_hi, cap_lo}, exp_v); else n_pass++;
        n_total++; if (fin_hilo !== exp_v) $display("FAIL hold3_hilo_hold: got %h expected %h", fin_hilo, exp_v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s0, v0, n;
        logic seen_busy;
        model_prod = 32'h0000_0015;
        model_hold = 1;
        model_lat  = 2;
        seen_busy  = 1'b0;
        exp_q.push_back(32'h0000_0015);
        @(negedge clk);
        s0 = st_total; v0 = valid_total;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.OpA = 16'h0003; bus.OpB = 16'h0007;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (bus.Busy) seen_busy = 1'b1;
            if (seen_busy && !bus.Busy) break;
            bus.OpA    = W'($urandom);
            bus.OpB    = W'($urandom);
            bus.Signed = 1'($urandom);
            n++;
        end
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        exp_v = exp_q.pop_front();
        n_total++; if ({seen_busy, bus.Busy} !== 2'b10) $display("FAIL b2b_complete: got seen/busy %b expected 10", {seen_busy, bus.Busy}); else n_pass++;
        n_total++; if (st_total - s0 !== 1) $display("FAIL b2b_st_count: got %0d expected 1", st_total - s0); else n_pass++;
        n_total++; if (valid_total - v0 !== 1) $display("FAIL b2b_valid_count: got %0d expected 1", valid_total - v0); else n_pass++;
        n_total++; if ({bus.Hi, bus.Lo} !== exp_v) $display("FAIL b2b_hilo: got %h expected %h", {bus.Hi, bus.Lo}, exp_v); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int v0, n, early;
        model_prod = 32'h1234_5678;
        model_hold = 1;
        model_lat  = 4;
        early      = 0;
        @(negedge clk);
        v0 = valid_total;
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.OpA = 16'h1234; bus.OpB = 16'h0002;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        n_total++; if (state_dbg !== S_WAIT) $display("FAIL abort_in_wait: got %0d expected %0d", state_dbg, S_WAIT); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_total++; if ({bus.Hi, bus.Lo, bus.Busy} !== 33'h0) $display("FAIL abort_cleared: got hilo %h busy %b expected 0/0", {bus.Hi, bus.Lo}, bus.Busy); else n_pass++;
        bus.Start = 1'b1; bus.Signed = 1'b1; bus.OpA = 16'h0003; bus.OpB = 16'h0004;
        n = 0;
        while (!Idle && n < 40) begin
            if (St || bus.Busy) early++;
            @(negedge clk);
            n++;
        end
        n_total++; if ({Idle, early} !== {1'b1, 32'sd0}) $display("FAIL abort_wait_idle: got idle %b early launches %0d expected 1/0", Idle, early); else n_pass++;
        n_total++; if (valid_total - v0 !== 0) $display("FAIL abort_stale_done_valid: got %0d expected 0", valid_total - v0); else n_pass++;
        n_total++; if ({bus.Hi, bus.Lo} !== 32'h0) $display("FAIL abort_stale_done_hilo: got %h expected 00000000", {bus.Hi, bus.Lo}); else n_pass++;
        model_prod = 32'h0000_000C;
        model_lat  = 2;
        n = 0;
        while (!St && n < 10) begin @(negedge clk); n++; end
        bus.Start = 1'b0;
        n_total++; if ({St, n} !== {1'b1, 32'sd1}) $display("FAIL abort_relaunch: got St %b after %0d cycles expected 1 after 1", St, n); else n_pass++;
        n_total++; if ({mcand, mplier} !== 32'h0003_0004) $display("FAIL abort_relaunch_operands: got %h expected 00030004", {mcand, mplier}); else n_pass++;
        n = 0;
        while (valid_total == v0 && n < 40) begin @(negedge clk); n++; end
        n_total++; if ({cap_hi, cap_lo} !== 32'h0000_000C || valid_total - v0 !== 1) $display("FAIL abort_relaunch_hilo: got %h valid count %0d expected 0000000c/1", {cap_hi, cap_lo}, valid_total - v0); else n_pass++;
        n = 0;
        while (bus.Busy && n < 40) begin @(negedge clk); n++; end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.OpA    = '0;
        bus.OpB    = '0;
        test_reset();
        test_multu_max();
        test_vectors();
        test_hold3();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
